// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO slot bus initiator.
package mmio_pkg;

  localparam int SLOT_IDX_W = 6;
  localparam int REG_IDX_W  = 5;
  localparam int DATA_W     = 32;

  localparam logic [DATA_W-1:0] DECERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } mmio_state_t;

endpackage

// File: rtl/mmio_slot_decoder.sv
// Combinational slot decode: one-hot chip select, in-range flag and read-data mux.
module mmio_slot_decoder
  import mmio_pkg::*;
#(
  parameter int SLOT_NUM = 64
) (
  input  logic                       en_i,
  input  logic [SLOT_IDX_W-1:0]      slot_idx_i,
  input  logic [SLOT_NUM*DATA_W-1:0] slot_rd_data_i,
  output logic [SLOT_NUM-1:0]        cs_o,
  output logic                       in_range_o,
  output logic [DATA_W-1:0]          rd_data_o
);

  localparam logic [SLOT_IDX_W:0] SLOT_LIM = (SLOT_IDX_W+1)'(SLOT_NUM);

  assign in_range_o = ({1'b0, slot_idx_i} < SLOT_LIM);

  // Unimplemented slot indices match no entry, giving no cs and zero data.
  always_comb begin
    cs_o      = '0;
    rd_data_o = '0;
    for (int i = 0; i < SLOT_NUM; i++) begin
      if (slot_idx_i == SLOT_IDX_W'(i)) begin
        cs_o[i]   = en_i;
        rd_data_o = slot_rd_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/mmio_slot_master.sv
// Initiator end of the MMIO slot bus: one request, one single-cycle slot access, one response.
// Optional feature: define MMIO_DECODE_ERR_EN to flag out-of-range slots with rsp_err and DEAD_BEEF data.
module mmio_slot_master
  import mmio_pkg::*;
#(
  parameter int SLOT_NUM = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [10:0]                req_addr,
  input  logic [31:0]                req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [31:0]                rsp_rdata,
  output logic                       rsp_err,
  output logic [SLOT_NUM-1:0]        slot_cs,
  output logic                       slot_read,
  output logic                       slot_write,
  output logic [4:0]                 slot_addr,
  output logic [31:0]                slot_wr_data,
  input  logic [SLOT_NUM*32-1:0]     slot_rd_data
);

  mmio_state_t state_q, state_d;

  logic                  accept;
  logic [SLOT_IDX_W-1:0] slot_q, slot_d;
  logic                  wr_q;
  logic [REG_IDX_W-1:0]  addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [SLOT_NUM-1:0]   cs_q, cs_d;
  logic                  rd_stb_q, rd_stb_d;
  logic                  wr_stb_q, wr_stb_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [DATA_W-1:0]     dec_rdata;
  logic                  dec_in_range;

  assign accept = (state_q == IDLE) && req_valid;

  // Decode on the next slot latch value: the request index when accepting,
  // and the held index during ACCESS, so the read mux follows the live access.
  assign slot_d = accept ? req_addr[SLOT_IDX_W+REG_IDX_W-1:REG_IDX_W] : slot_q;

  mmio_slot_decoder #(
    .SLOT_NUM (SLOT_NUM)
  ) u_decoder (
    .en_i           (accept),
    .slot_idx_i     (slot_d),
    .slot_rd_data_i (slot_rd_data),
    .cs_o           (cs_d),
    .in_range_o     (dec_in_range),
    .rd_data_o      (dec_rdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered at acceptance so they are flop outputs during ACCESS.
  always_comb begin
    rd_stb_d = accept && !req_write && dec_in_range;
    wr_stb_d = accept &&  req_write && dec_in_range;
    rdata_d  = wr_q ? '0 : dec_rdata;
`ifdef MMIO_DECODE_ERR_EN
    if (!dec_in_range) rdata_d = DECERR_DATA;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cs_q     <= '0;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cs_q     <= cs_d;
      rd_stb_q <= rd_stb_d;
      wr_stb_q <= wr_stb_d;
      if (accept) begin
        addr_q  <= req_addr[REG_IDX_W-1:0];
        wdata_q <= req_wdata;
      end
      if (state_q == ACCESS) rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      slot_q <= slot_d;
      wr_q   <= req_write;
    end
  end

`ifdef MMIO_DECODE_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = !dec_in_range;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state_q == ACCESS) begin
      err_q <= err_d;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == RESP);
  assign rsp_rdata    = rdata_q;
  assign slot_cs      = cs_q;
  assign slot_read    = rd_stb_q;
  assign slot_write   = wr_stb_q;
  assign slot_addr    = addr_q;
  assign slot_wr_data = wdata_q;

endmodule

// File: tb/tb_mmio_slot_master.sv
// Directed bench for mmio_slot_master with 16 implemented slots.
module tb_mmio_slot_master;

  localparam int NS = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [10:0]     req_addr;
  logic [31:0]     req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic [NS-1:0]   slot_cs;
  logic            slot_read;
  logic            slot_write;
  logic [4:0]      slot_addr;
  logic [31:0]     slot_wr_data;
  logic [NS*32-1:0] slot_rd_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mmio_slot_master #(.SLOT_NUM(NS)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .slot_cs      (slot_cs),
    .slot_read    (slot_read),
    .slot_write   (slot_write),
    .slot_addr    (slot_addr),
    .slot_wr_data (slot_wr_data),
    .slot_rd_data (slot_rd_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input int slot, input int rg, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = {6'(slot), 5'(rg)};
    req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic strobes_idle(input string tag);
    chk({tag, "_cs"}, 64'(slot_cs), 64'h0);
    chk({tag, "_rd"}, 64'(slot_read), 64'h0);
    chk({tag, "_wr"}, 64'(slot_write), 64'h0);
  endtask

  int slots [8] = '{1, 2, 3, 4, 6, 7, 9, 15};

  initial begin
    int idx, nstb, last_cyc;
    logic acc;

    reset        = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    rsp_ready    = 1'b1;
    slot_rd_data = '1;
    slot_rd_data[5*32 +: 32] = 32'h1234_5678;
    tick();
    tick();

    // reset state
    chk("rst_req_ready", 64'(req_ready), 64'h1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rdata", 64'(rsp_rdata), 64'h0);
    chk("rst_err", 64'(rsp_err), 64'h0);
    chk("rst_addr", 64'(slot_addr), 64'h0);
    chk("rst_wdata", 64'(slot_wr_data), 64'h0);
    strobes_idle("rst");
    reset = 1'b0;
    tick();

    // write slot 0 reg 2 data 3
    issue(1'b1, 0, 2, 32'h0000_0003);
    chk("w0_cs", 64'(slot_cs), 64'h1);
    chk("w0_write", 64'(slot_write), 64'h1);
    chk("w0_read", 64'(slot_read), 64'h0);
    chk("w0_addr", 64'(slot_addr), 64'h2);
    chk("w0_wdata", 64'(slot_wr_data), 64'h3);
    chk("w0_req_ready", 64'(req_ready), 64'h0);
    chk("w0_rsp_early", 64'(rsp_valid), 64'h0);
    tick();
    strobes_idle("w0_after");
    chk("w0_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("w0_rdata", 64'(rsp_rdata), 64'h0);
    chk("w0_addr_hold", 64'(slot_addr), 64'h2);
    tick();
    chk("w0_idle_ready", 64'(req_ready), 64'h1);
    chk("w0_idle_rsp", 64'(rsp_valid), 64'h0);

    // read slot 5 reg 0
    issue(1'b0, 5, 0, 32'h0);
    chk("r5_cs", 64'(slot_cs), 64'h20);
    chk("r5_read", 64'(slot_read), 64'h1);
    chk("r5_write", 64'(slot_write), 64'h0);
    chk("r5_addr", 64'(slot_addr), 64'h0);
    tick();
    chk("r5_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("r5_rdata", 64'(rsp_rdata), 64'h1234_5678);
    chk("r5_err", 64'(rsp_err), 64'h0);
    tick();

    // read with rsp_ready low for 3 cycles
    slot_rd_data[5*32 +: 32] = 32'hA5A5_0001;
    issue(1'b0, 5, 7, 32'h0);
    chk("st_read", 64'(slot_read), 64'h1);
    chk("st_addr", 64'(slot_addr), 64'h7);
    rsp_ready = 1'b0;
    tick();
    slot_rd_data[5*32 +: 32] = 32'h0BAD_0BAD;
    for (int k = 0; k < 3; k++) begin
      chk("st_rsp_valid", 64'(rsp_valid), 64'h1);
      chk("st_rdata", 64'(rsp_rdata), 64'hA5A5_0001);
      chk("st_req_ready", 64'(req_ready), 64'h0);
      strobes_idle("st");
      tick();
    end
    chk("st_4th_valid", 64'(rsp_valid), 64'h1);
    chk("st_4th_rdata", 64'(rsp_rdata), 64'hA5A5_0001);
    rsp_ready = 1'b1;
    tick();
    chk("st_done_rsp", 64'(rsp_valid), 64'h0);
    chk("st_done_ready", 64'(req_ready), 64'h1);

    // reset during ACCESS
    issue(1'b1, 3, 4, 32'hCAFE_0004);
    chk("ra_write", 64'(slot_write), 64'h1);
    chk("ra_cs", 64'(slot_cs), 64'h8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    strobes_idle("ra_after");
    chk("ra_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("ra_req_ready", 64'(req_ready), 64'h1);
    chk("ra_addr", 64'(slot_addr), 64'h0);
    chk("ra_wdata", 64'(slot_wr_data), 64'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ra_no_rsp", 64'(rsp_valid), 64'h0);
      chk("ra_no_stb", 64'(slot_write), 64'h0);
    end

    // out-of-range read (slot 20) and write (slot 63)
    issue(1'b0, 20, 1, 32'h0);
    strobes_idle("oor_r");
    chk("oor_r_req_ready", 64'(req_ready), 64'h0);
    tick();
    chk("oor_r_rsp_valid", 64'(rsp_valid), 64'h1);
`ifdef MMIO_DECODE_ERR_EN
    chk("oor_r_err", 64'(rsp_err), 64'h1);
    chk("oor_r_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
`else
    chk("oor_r_err", 64'(rsp_err), 64'h0);
    chk("oor_r_rdata", 64'(rsp_rdata), 64'h0);
`endif
    tick();
    issue(1'b1, 63, 0, 32'h5555_AAAA);
    strobes_idle("oor_w");
    tick();
    chk("oor_w_rsp_valid", 64'(rsp_valid), 64'h1);
`ifdef MMIO_DECODE_ERR_EN
    chk("oor_w_err", 64'(rsp_err), 64'h1);
    chk("oor_w_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
`else
    chk("oor_w_err", 64'(rsp_err), 64'h0);
    chk("oor_w_rdata", 64'(rsp_rdata), 64'h0);
`endif
    tick();
    issue(1'b0, 5, 0, 32'h0);
    tick();
    chk("post_oor_err", 64'(rsp_err), 64'h0);
    chk("post_oor_rdata", 64'(rsp_rdata), 64'h0BAD_0BAD);
    tick();

    // back-to-back writes, req_valid and rsp_ready held high
    idx       = 0;
    nstb      = 0;
    last_cyc  = 0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = {6'(slots[0]), 5'd1};
    req_wdata = 32'(slots[0] * 32'h11);
    for (int cyc = 0; cyc < 32; cyc++) begin
      acc = req_valid && req_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 8) begin
          req_addr  = {6'(slots[idx]), 5'd1};
          req_wdata = 32'(slots[idx] * 32'h11);
        end else begin
          req_valid = 1'b0;
        end
      end
      chk("b2b_no_read", 64'(slot_read), 64'h0);
      if (slot_write) begin
        if (nstb < 8) begin
          chk("b2b_cs", 64'(slot_cs), 64'(16'h1 << slots[nstb]));
          chk("b2b_wdata", 64'(slot_wr_data), 64'(slots[nstb] * 32'h11));
        end
        if (nstb > 0) chk("b2b_spacing", 64'(cyc - last_cyc), 64'd3);
        last_cyc = cyc;
        nstb++;
      end else begin
        chk("b2b_cs_idle", 64'(slot_cs), 64'h0);
      end
    end
    chk("b2b_strobe_count", 64'(nstb), 64'd8);
    chk("b2b_final_ready", 64'(req_ready), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_slot_master.md
# mmio_slot_master

Initiator end of the MMIO slot bus. Accepts single read/write requests from a processor-side valid/ready port, decodes the slot index, and drives the shared slot signals (`cs`, `read`, `write`, `addr`, `wr_data`) for exactly one cycle per access. It captures the selected slot's `rd_data` and returns it on a valid/ready response port. It sits between the CPU bus bridge and the slot array (timer, GPIO, UART, …).

## Interface
Parameters:
- `SLOT_NUM`, 64: number of implemented slots (1..64); width of the cs and rd_data arrays.

Ports (clock and reset are `clk` and `reset`; one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when high with `req_valid`
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  11  [10:5] slot index, [4:0] register index
- `req_wdata`  in  32  write data
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  response consumed when high with `rsp_valid`
- `rsp_rdata`  out  32  read data; 0 for writes
- `rsp_err`  out  1  decode error (see Configuration)
- `slot_cs`  out  SLOT_NUM  one-hot chip select
- `slot_read`  out  1  read strobe
- `slot_write`  out  1  write strobe
- `slot_addr`  out  5  register index
- `slot_wr_data`  out  32  write data
- `slot_rd_data`  in  SLOT_NUM×32 packed  per-slot read data, combinational from slots

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch write flag, slot, register and data, then go to ACCESS.
- ACCESS (one cycle):
  - Drive `slot_cs[slot]`=1, `slot_read`=!write, `slot_write`=write, and `slot_addr`/`slot_wr_data` from the latches.
  - Sample `slot_rd_data[slot]` into the response register at the end of the cycle. For writes, sample 0.
  - Go to RESP.
- RESP: `rsp_valid`=1. Hold `rsp_rdata`/`rsp_err` stable until `rsp_ready`, then go to IDLE.
- Outside ACCESS: `slot_cs`=0, `slot_read`=0, `slot_write`=0. Slot write side effects (e.g. counter clear) therefore fire exactly once per request.
- `slot_addr`/`slot_wr_data` hold their last values outside ACCESS. Slots ignore them without cs.
- Only one transaction is outstanding at a time. `req_ready`=0 in ACCESS and RESP.
- Reset (any state):
  - FSM to IDLE.
  - `slot_cs`, `slot_read`, `slot_write`, `rsp_valid`, `rsp_err` = 0.
  - `rsp_rdata`, `slot_addr`, `slot_wr_data` = 0.
  - An in-flight transaction is dropped with no response. Strobes drop on the same edge.

## Timing
- Request accepted at edge N.
- Slot strobes are high during cycle N+1, registered outputs only.
- `rsp_valid` rises at edge N+2.
- With `rsp_ready` held high, `req_ready` returns at N+3. Peak throughput is one access per 3 cycles.
- `rsp_ready` low for k cycles stretches RESP by k cycles. No slot activity occurs meanwhile.
- The read path is combinational from slot to the capture register. It must close in one cycle.

## Configuration
- `MMIO_DECODE_ERR_EN` defined:
  - A slot index ≥ `SLOT_NUM` asserts no cs and no strobes (the slot bus stays idle in ACCESS).
  - The response returns `rsp_err`=1 and `rsp_rdata`=32'hDEAD_BEEF for reads and writes.
- Undefined:
  - Out-of-range slots still assert no cs, and `rsp_rdata`=0.
  - `rsp_err` is tied to 0.
  - The FSM timing is identical in both builds.

## Structure
- Package `mmio_pkg`: `SLOT_IDX_W`=6, `REG_IDX_W`=5, `DATA_W`=32, `DECERR_DATA`=32'hDEAD_BEEF, state enum `mmio_state_t`.
- Sub-module `mmio_slot_decoder`, combinational:
  - Produces the one-hot `slot_cs` (gated by enable), the in-range flag, and the `slot_rd_data` mux.
- The FSM and registers live in the top module.

## Test plan
- Write slot 0 reg 2 data 0x0000_0003, accepted at N:
  - Cycle N+1: `slot_cs`=1<<0, `slot_write`=1, `slot_addr`=2, `slot_wr_data`=3, for exactly one cycle.
  - Edge N+2: `rsp_valid`=1, `rsp_rdata`=0.
- Read slot 5 reg 0 with `slot_rd_data[5]`=0x1234_5678 (other slots 0xFFFF_FFFF):
  - `slot_read`=1 and `slot_cs[5]`=1 only.
  - `rsp_rdata`=0x1234_5678.
- Read with `rsp_ready` low for 3 cycles:
  - `rsp_valid` and `rsp_rdata` stay stable.
  - `req_ready`=0 and strobes stay 0 throughout.
  - Accept completes on the 4th cycle.
- Assert `reset` during ACCESS:
  - Next cycle: all strobes/cs 0, `rsp_valid` 0, `req_ready` 1.
  - No response is ever issued.
- `SLOT_NUM`=16, read slot 20, with the macro:
  - No cs or strobes.
  - `rsp_err`=1, `rsp_rdata`=0xDEAD_BEEF.
  - Without the macro: `rsp_err`=0, `rsp_rdata`=0.
- Back-to-back: 8 writes to distinct slots with `req_valid` and `rsp_ready` held high:
  - Exactly 8 single-cycle strobes, spaced 3 cycles apart.
  - cs index matches each request.
